// File: rtl/pmt_counter_pkg.sv
// Shared definitions for the PMT acquisition counters (up counter and gated down counter).
package pmt_counter_pkg;

    localparam int CNT_WIDTH     = 8;
    localparam int WINDOWS_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : pmt_counter_pkg

// File: rtl/down_counter_gate.sv
// Loadable down counter that opens a timed gate window for PMT photon counting,
// with terminal-count pulse, optional auto-reload and a completed-window tally.
module down_counter_gate
    import pmt_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_value,
    input  logic                     enable,
    input  logic                     auto_reload,
    output logic [WIDTH-1:0]         count,
    output logic                     busy,
    output logic                     gate,
    output logic                     tc,
    output logic [WINDOWS_WIDTH-1:0] windows
);

    state_t                   state_reg, state_next;
    logic [WIDTH-1:0]         count_reg, count_next;
    logic [WIDTH-1:0]         preset_reg, preset_next;
    logic                     tc_reg, tc_next;
    logic [WINDOWS_WIDTH-1:0] windows_reg, windows_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            preset_reg  <= '0;
            tc_reg      <= 1'b0;
            windows_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            preset_reg  <= preset_next;
            tc_reg      <= tc_next;
            windows_reg <= windows_next;
        end
    end

    // Priority: clear > load > decrement. RUN never holds a zero count, so the
    // count==1 check is the only route back to zero and underflow cannot occur.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        preset_next  = preset_reg;
        tc_next      = 1'b0;
        windows_next = windows_reg;

        if (clear) begin
            count_next = '0;
            state_next = IDLE;
        end else if (load) begin
            count_next   = load_value;
            preset_next  = load_value;
            windows_next = '0;
            state_next   = (load_value != '0) ? RUN : IDLE;
        end else if (state_reg == RUN && enable) begin
            if (count_reg == WIDTH'(1)) begin
                tc_next      = 1'b1;
                windows_next = windows_reg + 1'b1;
                if (auto_reload) begin
                    count_next = preset_reg;
                end else begin
                    count_next = '0;
                    state_next = IDLE;
                end
            end else begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    assign count   = count_reg;
    assign busy    = (state_reg == RUN);
    assign gate    = (state_reg == RUN);
    assign tc      = tc_reg;
    assign windows = windows_reg;

endmodule : down_counter_gate

// File: tb/tb_down_counter_gate.sv
// Self-checking bench for down_counter_gate: directed scenarios plus random traffic
// compared against a window-progress model (elapsed enabled cycles vs. preset).
module tb_down_counter_gate;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       auto_reload;
    logic [7:0] count;
    logic       busy;
    logic       gate;
    logic       tc;
    logic [7:0] windows;

    int checks   = 0;
    int failures = 0;

    // Model: a window is `preset_m` enabled cycles long; `elapsed_m` says how far in we are.
    bit running_m = 0;
    int preset_m  = 0;
    int elapsed_m = 0;
    int wins_m    = 0;
    bit tc_m      = 0;

    down_counter_gate #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .gate        (gate),
        .tc          (tc),
        .windows     (windows)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_count;
        exp_count = running_m ? (preset_m - elapsed_m) : 0;
        check({tag, ".count"},   {24'd0, count},   exp_count);
        check({tag, ".busy"},    {31'd0, busy},    {31'd0, running_m});
        check({tag, ".gate"},    {31'd0, gate},    {31'd0, running_m});
        check({tag, ".tc"},      {31'd0, tc},      {31'd0, tc_m});
        check({tag, ".windows"}, {24'd0, windows}, wins_m % 256);
        $display("txn %s: count=%0d busy=%0b tc=%0b windows=%0d", tag, count, busy, tc, windows);
    endtask

    task automatic model_reset();
        running_m = 0; preset_m = 0; elapsed_m = 0; wins_m = 0; tc_m = 0;
    endtask

    task automatic model_step(input bit c, input bit l, input int lv, input bit e, input bit a);
        tc_m = 0;
        if (c) begin
            running_m = 0;
            elapsed_m = 0;
        end else if (l) begin
            preset_m  = lv;
            elapsed_m = 0;
            running_m = (lv != 0);
            wins_m    = 0;
        end else if (running_m && e) begin
            elapsed_m++;
            if (elapsed_m == preset_m) begin
                tc_m   = 1;
                wins_m = (wins_m + 1) % 256;
                elapsed_m = 0;
                if (!a) running_m = 0;
            end
        end
    endtask

    task automatic step(input string tag, input bit c, input bit l, input logic [7:0] lv,
                        input bit e, input bit a);
        clear = c; load = l; load_value = lv; enable = e; auto_reload = a;
        @(posedge clk);
        #1;
        model_step(c, l, int'(lv), e, a);
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; clear = 0; load = 0; load_value = 0; enable = 0; auto_reload = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Mid-run asynchronous reset with count at 5
        step("rst_load", 0, 1, 8'd9, 0, 0);
        for (int i = 0; i < 4; i++) step("rst_run", 0, 0, 0, 1, 0);
        check("rst_pre.count", {24'd0, count}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        reset = 1'b1;

        // Single window of 4, no reload
        step("w4_load", 0, 1, 8'd4, 1, 0);
        for (int i = 0; i < 4; i++) step("w4_run", 0, 0, 0, 1, 0);
        check("w4_end.tc", {31'd0, tc}, 32'd1);
        step("w4_idle", 0, 0, 0, 1, 0);
        step("w4_idle", 0, 0, 0, 1, 1);

        // Auto-reload windows of 3
        step("ar3_load", 0, 1, 8'd3, 1, 1);
        for (int i = 0; i < 9; i++) step("ar3_run", 0, 0, 0, 1, 1);
        check("ar3_end.windows", {24'd0, windows}, 32'd3);

        // Enable gaps inside a window of 5
        step("en5_load", 0, 1, 8'd5, 0, 0);
        begin
            bit en_pat [7] = '{1, 0, 0, 1, 1, 1, 1};
            for (int i = 0; i < 7; i++) step("en5_run", 0, 0, 0, en_pat[i], 0);
        end

        // Load takes priority over the terminal edge, then clear does
        step("ld_pri_load", 0, 1, 8'd2, 1, 0);
        step("ld_pri_run", 0, 0, 0, 1, 0);
        step("ld_pri_reload", 0, 1, 8'd7, 1, 0);
        step("clr_pri_load", 0, 1, 8'd2, 1, 1);
        step("clr_pri_run", 0, 0, 0, 1, 1);
        step("clr_pri_clear", 1, 0, 0, 1, 1);
        step("clr_idle", 0, 0, 0, 1, 1);

        // Zero preset never starts
        step("zero_load", 0, 1, 8'd0, 1, 1);
        for (int i = 0; i < 3; i++) step("zero_idle", 0, 0, 0, 1, 1);

        // 256 auto-reload windows of length 1 wrap the tally
        step("wrap_load", 0, 1, 8'd1, 1, 1);
        for (int i = 0; i < 256; i++) step("wrap_run", 0, 0, 0, 1, 1);
        check("wrap_end.windows", {24'd0, windows}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit c, l, e, a;
            logic [7:0] lv;
            c  = ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            a  = $urandom_range(0, 1);
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            step("rand", c, l, lv, e, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter_gate
